// File: rtl/physical_register_file_mp.sv
// ---------------------------------------------------------------------------
// physical_register_file_mp
//
// Multi-ported physical register file with a per-register ready scoreboard.
// Rename/issue read it through NUM_RD combinational ports and allocate
// registers (clearing their ready bit). The writeback bus writes it through
// NUM_WR synchronous ports, which set the ready bit again. With BYPASS = 1 a
// write is visible on the read ports in the same cycle it is presented.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   arst_n     asynchronous active-low reset (data = 0, ready = 1)
//   rd_dir     NUM_RD read indices, port k at [k*DIR_WIDTH +: DIR_WIDTH]
//   rd_data    NUM_RD read data,    port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_ready   NUM_RD scoreboard ready bits
//   wr_en      NUM_WR write enables
//   wr_dir     NUM_WR write indices
//   wr_data    NUM_WR write data
//   alloc_en   allocate alloc_dir (clear its ready bit)
//   alloc_dir  register being allocated
//
// Register 0 is hard-wired: it reads 0 / ready, and writes and allocs to it
// are dropped (never stored, never bypassed).
// ---------------------------------------------------------------------------
module physical_register_file_mp #(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [NUM_RD*DIR_WIDTH-1:0]    rd_dir,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_ready,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*DIR_WIDTH-1:0]    wr_dir,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
  input  logic                           alloc_en,
  input  logic [DIR_WIDTH-1:0]           alloc_dir
);

  localparam int NREG = 1 << DIR_WIDTH;

  logic [DATA_WIDTH-1:0] data_q [NREG];
  logic [DATA_WIDTH-1:0] data_d [NREG];
  logic [NREG-1:0]       ready_q;
  logic [NREG-1:0]       ready_d;

  // Next-state: writes are applied in ascending port order so the highest
  // enabled port wins a write/write conflict; the alloc is applied last so it
  // wins over a write to the same register (data still lands).
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_dir[j*DIR_WIDTH +: DIR_WIDTH] != '0)) begin
        data_d[wr_dir[j*DIR_WIDTH +: DIR_WIDTH]]  = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        ready_d[wr_dir[j*DIR_WIDTH +: DIR_WIDTH]] = 1'b1;
      end
    end
    if (alloc_en && (alloc_dir != '0)) begin
      ready_d[alloc_dir] = 1'b0;
    end
    data_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= data_d[i];
      end
      ready_q <= ready_d;
    end
  end

  // Read ports. Bypass is gated by arst_n so that asserting reset clears the
  // outputs immediately even if the writeback bus is still driving.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [DIR_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rrdy;

    assign idx = rd_dir[gi*DIR_WIDTH +: DIR_WIDTH];

    always_comb begin
      rdata = data_q[idx];
      rrdy  = ready_q[idx];
      if ((BYPASS != 0) && arst_n && (idx != '0)) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_dir[j*DIR_WIDTH +: DIR_WIDTH] == idx)) begin
            rdata = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            rrdy  = 1'b1;
          end
        end
      end
      if (idx == '0) begin
        rdata = '0;
        rrdy  = 1'b1;
      end
    end

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign rd_ready[gi]                         = rrdy;
  end

endmodule

// File: tb/tb_physical_register_file_mp.sv
module tb_physical_register_file_mp;

  localparam int DW   = 5;
  localparam int XW   = 32;
  localparam int NR   = 4;
  localparam int NW   = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                arst_n;
  logic [NR*DW-1:0]    rd_dir;
  logic [NW-1:0]       wr_en;
  logic [NW*DW-1:0]    wr_dir;
  logic [NW*XW-1:0]    wr_data;
  logic                alloc_en;
  logic [DW-1:0]       alloc_dir;

  logic [NR*XW-1:0]    rd_data_b, rd_data_n;
  logic [NR-1:0]       rd_ready_b, rd_ready_n;

  physical_register_file_mp #(.DIR_WIDTH(DW), .DATA_WIDTH(XW), .NUM_RD(NR),
                              .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk(clk), .arst_n(arst_n), .rd_dir(rd_dir), .rd_data(rd_data_b),
    .rd_ready(rd_ready_b), .wr_en(wr_en), .wr_dir(wr_dir), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_dir(alloc_dir));

  physical_register_file_mp #(.DIR_WIDTH(DW), .DATA_WIDTH(XW), .NUM_RD(NR),
                              .NUM_WR(NW), .BYPASS(0)) dut_n (
    .clk(clk), .arst_n(arst_n), .rd_dir(rd_dir), .rd_data(rd_data_n),
    .rd_ready(rd_ready_n), .wr_en(wr_en), .wr_dir(wr_dir), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_dir(alloc_dir));

  typedef struct {
    int               id;
    logic [NR*DW-1:0] dir;
    logic [NR*XW-1:0] d_b;
    logic [NR*XW-1:0] d_n;
    logic [NR-1:0]    r_b;
    logic [NR-1:0]    r_n;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural contents of the register file.
  logic [XW-1:0] m_data [NREG];
  logic          m_rdy  [NREG];

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_rdy[i]  = 1'b1;
    end
  endfunction

  // What one read port should show given the model and the inputs now driven.
  function automatic void predict(input bit byp, input logic [DW-1:0] idx,
                                  output logic [XW-1:0] d, output logic r);
    if (!arst_n || idx == 0) begin
      d = '0;
      r = 1'b1;
    end else begin
      d = m_data[idx];
      r = m_rdy[idx];
      if (byp) begin
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && wr_dir[j*DW +: DW] == idx) begin
            d = wr_data[j*XW +: XW];
            r = 1'b1;
          end
        end
      end
    end
  endfunction

  // One cycle: commit the previous cycle's inputs into the model at the edge,
  // then drive new inputs and queue what the read ports must show.
  task automatic apply(input logic rst, input logic [NW-1:0] we,
                       input logic [NW*DW-1:0] wd, input logic [NW*XW-1:0] wv,
                       input logic ae, input logic [DW-1:0] ad,
                       input logic [NR*DW-1:0] rd);
    exp_t e;
    logic [XW-1:0] d;
    logic          r;
    @(posedge clk);
    if (arst_n) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && wr_dir[j*DW +: DW] != 0) begin
          m_data[wr_dir[j*DW +: DW]] = wr_data[j*XW +: XW];
          m_rdy[wr_dir[j*DW +: DW]]  = 1'b1;
        end
      end
      if (alloc_en && alloc_dir != 0) m_rdy[alloc_dir] = 1'b0;
    end
    #1;
    arst_n    = rst;
    wr_en     = we;
    wr_dir    = wd;
    wr_data   = wv;
    alloc_en  = ae;
    alloc_dir = ad;
    rd_dir    = rd;
    if (!rst) model_reset();
    e.id  = txn;
    e.dir = rd;
    for (int k = 0; k < NR; k++) begin
      predict(1'b1, rd[k*DW +: DW], d, r);
      e.d_b[k*XW +: XW] = d;
      e.r_b[k]          = r;
      predict(1'b0, rd[k*DW +: DW], d, r);
      e.d_n[k*XW +: XW] = d;
      e.r_n[k]          = r;
    end
    exp_q.push_back(e);
    txn++;
  endtask

  // Monitor: read ports are always presenting, sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NR; k++) begin
          tests++;
          if (rd_data_b[k*XW +: XW] !== e.d_b[k*XW +: XW] || rd_ready_b[k] !== e.r_b[k]) begin
            fails++;
            $display("FAIL byp txn=%0d port%0d reg=%0d got data=%h rdy=%b exp data=%h rdy=%b",
                     e.id, k, e.dir[k*DW +: DW], rd_data_b[k*XW +: XW], rd_ready_b[k],
                     e.d_b[k*XW +: XW], e.r_b[k]);
          end
          tests++;
          if (rd_data_n[k*XW +: XW] !== e.d_n[k*XW +: XW] || rd_ready_n[k] !== e.r_n[k]) begin
            fails++;
            $display("FAIL nobyp txn=%0d port%0d reg=%0d got data=%h rdy=%b exp data=%h rdy=%b",
                     e.id, k, e.dir[k*DW +: DW], rd_data_n[k*XW +: XW], rd_ready_n[k],
                     e.d_n[k*XW +: XW], e.r_n[k]);
          end
        end
        $display("[TB] txn %0d rd_dir=%h byp_data=%h nobyp_data=%h rdy=%b/%b", e.id, e.dir,
                 rd_data_b, rd_data_n, rd_ready_b, rd_ready_n);
      end
    end
  end

  function automatic logic [NR*DW-1:0] all_rd(input logic [DW-1:0] idx);
    return {NR{idx}};
  endfunction

  initial begin
    logic [NW-1:0]    we;
    logic [NW*DW-1:0] wd;
    logic [NW*XW-1:0] wv;
    logic [NR*DW-1:0] rd;
    logic [DW-1:0]    t;

    arst_n = 1'b0; wr_en = '0; wr_dir = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_dir = '0; rd_dir = '0;
    model_reset();

    apply(1'b0, 2'b00, '0, '0, 1'b0, '0, {5'd3, 5'd2, 5'd1, 5'd0});
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, {5'd3, 5'd2, 5'd1, 5'd0});

    // Basic write/read of reg 5 (same cycle shows bypass vs stored).
    apply(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0, '0, all_rd(5'd5));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd5));
    // Register 0 protection.
    apply(1'b1, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1'b1, 5'd0, all_rd(5'd0));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd0));
    // Bypass of reg 9.
    apply(1'b1, 2'b10, {5'd9, 5'd0}, {32'hA5A5A5A5, 32'h0}, 1'b0, '0, all_rd(5'd9));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd9));
    // Scoreboard on reg 7.
    apply(1'b1, 2'b00, '0, '0, 1'b1, 5'd7, all_rd(5'd7));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd7));
    apply(1'b1, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 1'b0, '0, all_rd(5'd7));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd7));
    apply(1'b1, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 1'b1, 5'd7, all_rd(5'd7));
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, all_rd(5'd7));
    // Write/write conflict on reg 12.
    apply(1'b1, 2'b11, {5'd12, 5'd12}, {32'h22, 32'h11}, 1'b0, '0, {5'd12, 5'd0, 5'd12, 5'd7});
    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, {5'd9, 5'd5, 5'd12, 5'd12});

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      we = NW'($urandom);
      for (int j = 0; j < NW; j++) begin
        t = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
        wd[j*DW +: DW] = t;
        wv[j*XW +: XW] = $urandom;
      end
      for (int k = 0; k < NR; k++) begin
        rd[k*DW +: DW] = ($urandom_range(0, 2) == 0) ? wd[($urandom_range(0, NW-1))*DW +: DW]
                                                     : DW'($urandom_range(0, 11));
      end
      apply((i >= 200 && i < 203) ? 1'b0 : 1'b1, we, wd, wv, ($urandom_range(0, 3) == 0),
            DW'($urandom_range(0, 11)), rd);
    end

    apply(1'b1, 2'b00, '0, '0, 1'b0, '0, {5'd3, 5'd2, 5'd1, 5'd0});
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/physical_register_file_mp.md
Name: physical_register_file_mp

Overview:
Multi-ported physical register file for the out-of-order core. It has NUM_RD combinational read ports and NUM_WR synchronous write ports, plus a per-register ready scoreboard that is cleared on rename allocation and set on writeback. Same-cycle writeback data can be bypassed to the read ports. It sits between rename/issue (reads, alloc) and the writeback bus (writes).

Parameters:
DIR_WIDTH, 5, physical register index width; depth NREG = 2**DIR_WIDTH.
DATA_WIDTH, 32, register data width.
NUM_RD, 4, number of read ports.
NUM_WR, 2, number of write ports.
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return the stored value only.

Ports:
clk  input  1  clock; all state updates on the rising edge.
arst_n  input  1  asynchronous active-low reset.
rd_dir  input  NUM_RD*DIR_WIDTH  read indices; port k at [k*DIR_WIDTH +: DIR_WIDTH].
rd_data  output  NUM_RD*DATA_WIDTH  read data; port k at [k*DATA_WIDTH +: DATA_WIDTH].
rd_ready  output  NUM_RD  scoreboard ready bit for each read index.
wr_en  input  NUM_WR  write enables.
wr_dir  input  NUM_WR*DIR_WIDTH  write indices.
wr_data  input  NUM_WR*DATA_WIDTH  write data.
alloc_en  input  1  rename allocates alloc_dir; its ready bit is cleared.
alloc_dir  input  DIR_WIDTH  register being allocated.

Behaviour:
- Reset (arst_n low, asynchronous): every data entry = 0; every ready bit = 1.
  - rd_data follows combinationally and reads 0.
  - rd_ready reads all 1.
  - Reset mid-operation discards in-flight writes and allocs of that cycle.
- Register 0:
  - Always reads 0 with rd_ready = 1.
  - Writes to it and allocs of it are ignored; they are never bypassed.
- Write:
  - On the rising edge with wr_en[j] = 1 and wr_dir[j] != 0: entry <= wr_data[j] and its ready bit <= 1.
- Write/write conflict:
  - Two enabled ports with the same wr_dir: the highest port index wins, for both storage and bypass.
- Alloc:
  - On the rising edge with alloc_en = 1 and alloc_dir != 0: that ready bit <= 0. Data is unchanged.
- Alloc/write conflict:
  - alloc_en and a write to the same index in the same cycle: data is written, and the ready bit ends at 0 (alloc wins).
- Read (combinational, zero latency):
  - rd_data[k] = stored entry; rd_ready[k] = stored ready bit.
- BYPASS = 1:
  - If any enabled write has wr_dir == rd_dir[k] (k != 0), rd_data[k] = that write's data (highest port wins) and rd_ready[k] = 1, in the same cycle.
  - A same-cycle alloc does not affect the read outputs until the next cycle.
- BYPASS = 0:
  - Reads see new data and ready from the cycle after the write edge.
- Read ports are independent. Any number of ports may address the same index.
- Indices are always in range (0..NREG-1); no wrap handling is needed.

Test Plan:
- Reset check: assert arst_n = 0 mid-run after writes.
  -> All rd_data = 0 and rd_ready = 1 immediately, without waiting for a clock.
- Basic write/read: write 0xDEADBEEF to reg 5 on port 0, then read reg 5 on all 4 ports the next cycle.
  -> All ports read 0xDEADBEEF with ready = 1.
- Register 0 protection: write 0x1234 to reg 0 and alloc reg 0.
  -> Reads of reg 0 give 0 with ready = 1 in the same cycle and later.
- Bypass: with BYPASS = 1, write 0xA5A5A5A5 to reg 9 while reading reg 9.
  -> rd_data = 0xA5A5A5A5 in the same cycle.
  -> With BYPASS = 0, the same stimulus returns the old value that cycle and the new value the next cycle.
- Scoreboard: alloc reg 7.
  -> rd_ready for reg 7 = 0 next cycle.
  -> A later write of 0x77 sets ready = 1: same cycle with bypass, next cycle with BYPASS = 0.
  -> Alloc plus write to reg 7 in the same cycle leaves data 0x77 and ready = 0.
- Port conflict: port 0 writes 0x11 and port 1 writes 0x22, both to reg 12 in the same cycle.
  -> Stored value and bypassed value are both 0x22.
